sha256_loop_ctrl: RTL and testbench



---
 rtl/sha256_loop_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sha256_loop_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_loop_ctrl.sv
// sha256_loop_ctrl
//   Sequencer for a 4-way interleaved SHA-256 compression loop. Four message
//   contexts share a 4-stage round pipeline, so 64 rounds take 256 cycles.
//   One chunk batch (one chunk per context) is accepted per handshake.
//
// Handshake: a batch is taken on a rising edge where blk_valid_i and
//   blk_ready_o are both high. blk_ready_o is high only in IDLE (and never
//   while rst_i is asserted), so blk_valid_i is ignored in every other state.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   blk_valid_i         chunk batch available
//   blk_first_i         batch starts new messages (contexts cleared first)
//   blk_last_i          batch is the final chunk (digests presented after)
//   blk_ready_o         controller can accept a batch
//   clr_no              active-low loop clear, one cycle per context slot
//   update_o            fold abcdefgh into the hash set
//   sched_en_o          message schedule / K-ROM advance enable
//   round_o             round index, also the K-ROM address
//   ctx_o               context in the issue slot
//   busy_o              controller not idle
//   digest_valid_o      hash outputs hold the final digest of digest_ctx_o
//   digest_ctx_o        context whose digest is presented
//   blk_cnt_o           completed batches (wraps)
//   dbg_state           current FSM state encoding
module sha256_loop_ctrl #(
  parameter int ROUNDS     = 64,
  parameter int CTX        = 4,
  parameter int FOLD_START = 256,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             blk_valid_i,
  input  logic             blk_first_i,
  input  logic             blk_last_i,
  output logic             blk_ready_o,
  output logic             clr_no,
  output logic             update_o,
  output logic             sched_en_o,
  output logic [5:0]       round_o,
  output logic [1:0]       ctx_o,
  output logic             busy_o,
  output logic             digest_valid_o,
  output logic [1:0]       digest_ctx_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    FOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [8:0] SLOT_LAST  = 9'(CTX - 1);
  localparam logic [8:0] RUN_LAST   = 9'(ROUNDS * CTX - 1);
  localparam logic [8:0] FOLD_FIRST = 9'(FOLD_START);
  localparam logic [8:0] FOLD_LAST  = 9'(FOLD_START + CTX - 1);
  localparam logic [5:0] ROUND_MAX  = 6'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [8:0]       cyc_q, cyc_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_d;

  // Next-cycle output values; registered so every output changes on the
  // same edge as the state.
  logic       clr_n_d, update_d, sched_d, busy_d, dvalid_d;
  logic [5:0] round_d;
  logic [1:0] ctx_d, dctx_d;

  assign blk_ready_o = (state_q == IDLE) && !rst_i;
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    last_d  = last_q;
    cnt_d   = blk_cnt_o;
    case (state_q)
      IDLE: begin
        if (blk_valid_i && blk_ready_o) begin
          last_d  = blk_last_i;
          cyc_d   = 9'd0;
          state_d = blk_first_i ? CLEAR : RUN;
        end
      end
      CLEAR: begin
        // cyc doubles as the context-slot index while clearing.
        if (cyc_q == SLOT_LAST) begin
          cyc_d   = 9'd0;
          state_d = RUN;
        end else begin
          cyc_d = cyc_q + 9'd1;
        end
      end
      RUN: begin
        // cyc keeps counting into FOLD so the fold window is an absolute
        // offset from RUN entry.
        cyc_d = cyc_q + 9'd1;
        if (cyc_q == RUN_LAST) state_d = FOLD;
      end
      FOLD: begin
        if (cyc_q == FOLD_LAST) begin
          cyc_d   = 9'd0;
          cnt_d   = blk_cnt_o + CNT_ONE;
          state_d = last_q ? DONE : IDLE;
        end else begin
          cyc_d = cyc_q + 9'd1;
        end
      end
      DONE: begin
        if (cyc_q == SLOT_LAST) begin
          cyc_d   = 9'd0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + 9'd1;
        end
      end
      default: begin
        cyc_d   = 9'd0;
        state_d = IDLE;
      end
    endcase

    clr_n_d  = (state_d != CLEAR);
    sched_d  = (state_d == RUN);
    busy_d   = (state_d != IDLE);
    update_d = (state_d == FOLD) && (cyc_d >= FOLD_FIRST) && (cyc_d <= FOLD_LAST);
    dvalid_d = (state_d == DONE);
    dctx_d   = (state_d == DONE) ? cyc_d[1:0] : 2'd0;
    round_d  = 6'd0;
    ctx_d    = 2'd0;
    case (state_d)
      CLEAR: ctx_d = cyc_d[1:0];
      RUN: begin
        round_d = cyc_d[7:2];
        ctx_d   = cyc_d[1:0];
      end
      FOLD: begin
        round_d = ROUND_MAX;
        ctx_d   = cyc_d[1:0];
      end
      default: begin
        round_d = 6'd0;
        ctx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cyc_q          <= 9'd0;
      last_q         <= 1'b0;
      blk_cnt_o      <= '0;
      clr_no         <= 1'b1;
      update_o       <= 1'b0;
      sched_en_o     <= 1'b0;
      round_o        <= 6'd0;
      ctx_o          <= 2'd0;
      busy_o         <= 1'b0;
      digest_valid_o <= 1'b0;
      digest_ctx_o   <= 2'd0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      last_q         <= last_d;
      blk_cnt_o      <= cnt_d;
      clr_no         <= clr_n_d;
      update_o       <= update_d;
      sched_en_o     <= sched_d;
      round_o        <= round_d;
      ctx_o          <= ctx_d;
      busy_o         <= busy_d;
      digest_valid_o <= dvalid_d;
      digest_ctx_o   <= dctx_d;
    end
  end

endmodule

// File: tb/tb_sha256_loop_ctrl.sv
// tb_sha256_loop_ctrl
//   Bench for sha256_loop_ctrl. The main instance uses default parameters
//   and is checked cycle by cycle against expected output vectors queued at
//   each handshake. A second instance (FOLD_START=260, CNT_W=2) covers the
//   delayed fold window and counter wrap.
module tb_sha256_loop_ctrl;

  logic clk;
  logic rst;

  // main instance
  logic        valid, first, last;
  logic        ready, clr_n, upd, sched, busy, dv;
  logic [5:0]  rnd;
  logic [1:0]  cx, dcx;
  logic [15:0] cnt;
  logic [2:0]  dbg;

  // alternate instance
  logic        a_valid, a_first, a_last;
  logic        a_ready, a_clr_n, a_upd, a_sched, a_busy, a_dv;
  logic [5:0]  a_rnd;
  logic [1:0]  a_cx, a_dcx;
  logic [1:0]  a_cnt;
  logic [2:0]  a_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] cnt_model = 16'd0;
  logic [31:0] obs;

  sha256_loop_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .blk_valid_i(valid), .blk_first_i(first), .blk_last_i(last),
    .blk_ready_o(ready), .clr_no(clr_n), .update_o(upd), .sched_en_o(sched),
    .round_o(rnd), .ctx_o(cx), .busy_o(busy), .digest_valid_o(dv),
    .digest_ctx_o(dcx), .blk_cnt_o(cnt), .dbg_state(dbg)
  );

  sha256_loop_ctrl #(.FOLD_START(260), .CNT_W(2)) dut_alt (
    .clk_i(clk), .rst_i(rst),
    .blk_valid_i(a_valid), .blk_first_i(a_first), .blk_last_i(a_last),
    .blk_ready_o(a_ready), .clr_no(a_clr_n), .update_o(a_upd), .sched_en_o(a_sched),
    .round_o(a_rnd), .ctx_o(a_cx), .busy_o(a_busy), .digest_valid_o(a_dv),
    .digest_ctx_o(a_dcx), .blk_cnt_o(a_cnt), .dbg_state(a_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] pack(
    input logic rdy, input logic bsy, input logic clrn, input logic sch,
    input logic up, input logic dval, input logic [5:0] r, input logic [1:0] c,
    input logic [1:0] dc, input logic [15:0] n);
    return {rdy, bsy, clrn, sch, up, dval, r, c, dc, n};
  endfunction

  assign obs = pack(ready, busy, clr_n, sched, upd, dv, rnd, cx, dcx, cnt);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one batch, starting with the cycle after
  // the accepting edge and ending with the first IDLE cycle.
  task automatic push_batch(input bit f, input bit l);
    if (f)
      for (int i = 0; i < 4; i++)
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'(i), 2'd0, cnt_model));
    for (int i = 0; i < 256; i++)
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'(i / 4), 2'(i % 4), 2'd0, cnt_model));
    for (int i = 256; i < 260; i++)
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd63, 2'(i % 4), 2'd0, cnt_model));
    cnt_model = cnt_model + 16'd1;
    if (l)
      for (int i = 0; i < 4; i++)
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 2'd0, 2'(i), cnt_model));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 2'd0, cnt_model));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_eq("seq", obs, exp_q.pop_front());
  end

  // ---------------- drivers ----------------
  task automatic send(input bit f, input bit l, input bit hold);
    int waited;
    @(negedge clk);
    valid = 1'b1; first = f; last = l;
    waited = 0;
    while (!ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      check_eq("ready_timeout", 32'(ready), 32'd1);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_batch(f, l);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() > 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // One batch on the alternate instance; when measure is set, check the
  // fold-window timing relative to RUN entry (batch must have first=0).
  task automatic alt_batch(input bit f, input bit l, input bit measure);
    int waited, k, first_upd, last_sched, n_upd, n_sched, overlap;
    logic [1:0] ctx_at_upd;
    @(negedge clk);
    a_valid = 1'b1; a_first = f; a_last = l;
    waited = 0;
    while (!a_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!a_ready) begin
      check_eq("alt_ready_timeout", 32'(a_ready), 32'd1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
    k = 0; first_upd = -1; last_sched = -1; n_upd = 0; n_sched = 0; overlap = 0;
    ctx_at_upd = 2'd3;
    do begin
      @(negedge clk);
      k++;
      if (a_sched) begin n_sched++; last_sched = k; end
      if (a_upd) begin
        n_upd++;
        if (first_upd < 0) begin first_upd = k; ctx_at_upd = a_cx; end
        if (a_sched) overlap++;
      end
    end while (a_busy && k < 2000);
    check_eq("alt_idle_timeout", 32'(a_busy), 32'd0);
    if (measure) begin
      // k=1 is RUN cycle cyc=0, so cyc=260 is k=261.
      check_eq("alt_first_upd", 32'(first_upd), 32'd261);
      check_eq("alt_fold_gap", 32'(first_upd - last_sched - 1), 32'd4);
      check_eq("alt_n_upd", 32'(n_upd), 32'd4);
      check_eq("alt_n_sched", 32'(n_sched), 32'd256);
      check_eq("alt_overlap", 32'(overlap), 32'd0);
      check_eq("alt_upd_ctx", 32'(ctx_at_upd), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] saved_cnt;
    rst = 1'b1;
    valid = 1'b0; first = 1'b0; last = 1'b0;
    a_valid = 1'b0; a_first = 1'b0; a_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", obs, pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 2'd0, 16'd0));
    check_eq("alt_reset_cnt", 32'(a_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("idle_after_reset", obs, pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 2'd0, 16'd0));

    // single batch, first and last
    send(1'b1, 1'b1, 1'b0);
    drain();
    check_eq("cnt_after_1", 32'(cnt), 32'd1);

    // two-chunk message with valid held through the first batch
    send(1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b1, 1'b0);
    drain();
    check_eq("cnt_after_3", 32'(cnt), 32'd3);

    // reset at RUN cyc=100 aborts without counting
    saved_cnt = cnt_model;
    send(1'b1, 1'b1, 1'b0);
    repeat (105) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    cnt_model = 16'd0;
    #1;
    check_eq("abort_outputs", obs, pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 2'd0, 16'd0));
    check_eq("abort_saved_nonzero", 32'(saved_cnt), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_idle", obs, pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 2'd0, 16'd0));

    // fresh batches after the abort, random flags
    for (int b = 0; b < 2; b++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      drain();
    end
    check_eq("cnt_after_abort", 32'(cnt), 32'd2);

    // alternate instance: delayed fold, then counter wrap at CNT_W=2
    alt_batch(1'b0, 1'b0, 1'b1);
    alt_batch(1'b1, 1'b1, 1'b0);
    alt_batch(1'b0, 1'b0, 1'b0);
    alt_batch(1'b1, 1'b0, 1'b0);
    check_eq("alt_cnt_wrap0", 32'(a_cnt), 32'd0);
    alt_batch(1'b0, 1'b1, 1'b0);
    check_eq("alt_cnt_wrap1", 32'(a_cnt), 32'd1);
    check_eq("main_untouched", 32'(cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
